oclib_bc_async_1b_receiver: RTL and testbench

- Sink end of the serial asynchronous byte channel (bc_async_1b).
- Deserializes toggle-encoded bits arriving on data[1:0] into bytes and presents them on a synchronous 8-bit ready/valid byte channel (bc_8b).
- Returns the ack as XOR-state feedback on bc_async_1b_fb.
- Sits at the receiving chip/block boundary, pairing with a bc_async_1b transmitter in another clock domain.

---
 rtl/oclib_bc_async_1b_receiver.sv | 85 ++++++++
 tb/tb_oclib_bc_async_1b_receiver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/oclib_bc_async_1b_receiver.sv
// Sink end of the toggle-encoded serial byte channel: resynchronizes data[1:0], deserializes to bytes,
// acks each bit by XOR-state feedback; a full shift register withholds the ack so the source stalls.
module oclib_bc_async_1b_receiver #(
  parameter int SyncCycles = 3,
  parameter bit MsbFirst   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] in,
  output logic       inFb,
  output logic [8:0] out,
  input  logic       outFb,
  output logic       error,
  input  logic       errorClear
);

  logic [1:0] sync_q [SyncCycles];
  logic [1:0] s;
  logic [1:0] seen;
  logic [7:0] shift_q;
  logic [3:0] bit_count;
  logic       ack_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       err_q;

  logic p0, p1, accept, both, handoff;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SyncCycles; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in;
      for (int i = 1; i < SyncCycles; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s       = sync_q[SyncCycles-1];
  assign p0      = s[0] ^ seen[0];
  assign p1      = s[1] ^ seen[1];
  assign accept  = (bit_count < 4'd8) && (p0 ^ p1);
  assign both    = p0 & p1;
  assign handoff = (bit_count == 4'd8) && (!out_valid || outFb);

  // On an accept the idle line already matches seen, so loading all of s is equivalent
  // to loading only the toggled bit; on an error it resynchronizes both lines at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      seen      <= '0;
      shift_q   <= '0;
      bit_count <= '0;
      ack_q     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept || both) begin
        seen  <= s;
        ack_q <= s[0] ^ s[1];
      end
      if (accept) begin
        shift_q   <= MsbFirst ? {shift_q[6:0], p1} : {p1, shift_q[7:1]};
        bit_count <= bit_count + 4'd1;
      end else if (handoff) begin
        bit_count <= '0;
      end
      if (handoff) begin
        out_data  <= shift_q;
        out_valid <= 1'b1;
      end else if (outFb) begin
        out_valid <= 1'b0;
      end
      if (both) begin
        err_q <= 1'b1;
      end else if (errorClear) begin
        err_q <= 1'b0;
      end
    end
  end

  assign inFb  = ack_q;
  assign out   = {out_data, out_valid};
  assign error = err_q;

endmodule

// File: tb/tb_oclib_bc_async_1b_receiver.sv
// Directed bench: four receiver instances (LSB-first, MSB-first, 2- and 5-stage synchronizers)
// driven by a toggle-encoding source model that waits for each bit's ack.
module tb_oclib_bc_async_1b_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       error_clear = 1'b0;
  logic [1:0] din  [4];
  logic       ack  [4];
  logic [8:0] dout [4];
  logic       rdy  [4];
  logic       err  [4];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  oclib_bc_async_1b_receiver #(.SyncCycles(3), .MsbFirst(1'b0)) dut0 (
    .clock(clock), .reset(reset), .in(din[0]), .inFb(ack[0]), .out(dout[0]),
    .outFb(rdy[0]), .error(err[0]), .errorClear(error_clear));
  oclib_bc_async_1b_receiver #(.SyncCycles(3), .MsbFirst(1'b1)) dut1 (
    .clock(clock), .reset(reset), .in(din[1]), .inFb(ack[1]), .out(dout[1]),
    .outFb(rdy[1]), .error(err[1]), .errorClear(error_clear));
  oclib_bc_async_1b_receiver #(.SyncCycles(2), .MsbFirst(1'b0)) dut2 (
    .clock(clock), .reset(reset), .in(din[2]), .inFb(ack[2]), .out(dout[2]),
    .outFb(rdy[2]), .error(err[2]), .errorClear(error_clear));
  oclib_bc_async_1b_receiver #(.SyncCycles(5), .MsbFirst(1'b0)) dut5 (
    .clock(clock), .reset(reset), .in(din[3]), .inFb(ack[3]), .out(dout[3]),
    .outFb(rdy[3]), .error(err[3]), .errorClear(error_clear));

  // Byte collector and counters for dut0, sampled away from the active edge.
  logic [7:0] rxq[$];
  int         vcnt    = 0;
  int         toggles = 0;
  logic       prev_ack = 1'b0;

  always @(negedge clock) begin
    if (dout[0][0] && rdy[0]) rxq.push_back(dout[0][8:1]);
    if (dout[0][0]) vcnt <= vcnt + 1;
    if (ack[0] !== prev_ack) toggles <= toggles + 1;
    prev_ack <= ack[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic toggle_bit(input int k, input bit b);
    tick(1);
    din[k][b] = ~din[k][b];
  endtask

  task automatic wait_ack(input int k, input string tag);
    int n = 0;
    while (ack[k] !== (din[k][0] ^ din[k][1]) && n < 30) begin
      tick(1);
      n++;
    end
    if (n >= 30) check(tag, {31'd0, ack[k]}, {31'd0, din[k][0] ^ din[k][1]});
  endtask

  task automatic send_byte(input int k, input logic [7:0] v, input bit msb);
    for (int i = 0; i < 8; i++) begin
      toggle_bit(k, msb ? v[7-i] : v[i]);
      wait_ack(k, "ack_timeout");
    end
  endtask

  int base_q, base_v, base_t, lat;
  logic [7:0] pat;

  initial begin
    for (int k = 0; k < 4; k++) begin
      din[k] = 2'b00;
      rdy[k] = 1'b1;
    end
    rdy[1] = 1'b0;
    tick(3);
    check("reset_valid", {31'd0, dout[0][0]}, 0);
    check("reset_data", {24'd0, dout[0][8:1]}, 0);
    check("reset_ack", {31'd0, ack[0]}, 0);
    check("reset_error", {31'd0, err[0]}, 0);
    reset = 1'b0;
    tick(2);

    // 0xA5 LSB-first with ready held high
    base_q = rxq.size(); base_v = vcnt; base_t = toggles;
    send_byte(0, 8'hA5, 1'b0);
    tick(5);
    check("a5_count", rxq.size() - base_q, 1);
    check("a5_data", {24'd0, rxq[base_q]}, 32'hA5);
    check("a5_valid_cycles", vcnt - base_v, 1);
    check("a5_toggles", toggles - base_t, 8);
    check("a5_ack_end", {31'd0, ack[0]}, 0);

    // MSB-first instance, held in output register since its ready is low
    send_byte(1, 8'hC1, 1'b1);
    tick(3);
    check("msb_valid", {31'd0, dout[1][0]}, 1);
    check("msb_data", {24'd0, dout[1][8:1]}, 32'hC1);

    // Backpressure: two bytes fill output and shift register, third bit stalls
    rdy[0] = 1'b0;
    base_q = rxq.size(); base_t = toggles;
    send_byte(0, 8'h11, 1'b0);
    send_byte(0, 8'h22, 1'b0);
    pat = 8'h33;
    toggle_bit(0, pat[0]);
    tick(10);
    check("bp_toggles", toggles - base_t, 16);
    check("bp_ack_frozen", {31'd0, ack[0]}, 0);
    check("bp_bitcount", {28'd0, dut0.bit_count}, 8);
    check("bp_held_valid", {31'd0, dout[0][0]}, 1);
    check("bp_held_data", {24'd0, dout[0][8:1]}, 32'h11);
    rdy[0] = 1'b1;
    wait_ack(0, "bp_resume_timeout");
    for (int i = 1; i < 8; i++) begin
      toggle_bit(0, pat[i]);
      wait_ack(0, "ack_timeout");
    end
    tick(5);
    check("bp_count", rxq.size() - base_q, 3);
    check("bp_byte0", {24'd0, rxq[base_q]}, 32'h11);
    check("bp_byte1", {24'd0, rxq[base_q+1]}, 32'h22);
    check("bp_byte2", {24'd0, rxq[base_q+2]}, 32'h33);

    // Protocol error: both lines toggle together
    tick(1);
    din[0] = ~din[0];
    tick(6);
    check("err_set", {31'd0, err[0]}, 1);
    check("err_ack", {31'd0, ack[0]}, {31'd0, din[0][0] ^ din[0][1]});
    check("err_bitcount", {28'd0, dut0.bit_count}, 0);
    base_q = rxq.size();
    send_byte(0, 8'h5A, 1'b0);
    tick(5);
    check("err_next_count", rxq.size() - base_q, 1);
    check("err_next_data", {24'd0, rxq[base_q]}, 32'h5A);
    check("err_sticky", {31'd0, err[0]}, 1);
    error_clear = 1'b1;
    tick(1);
    error_clear = 1'b0;
    tick(1);
    check("err_cleared", {31'd0, err[0]}, 0);

    // Reset with a held byte and a partial byte in flight
    rdy[0] = 1'b0;
    send_byte(0, 8'h77, 1'b0);
    for (int i = 0; i < 4; i++) begin
      toggle_bit(0, 1'b1);
      wait_ack(0, "ack_timeout");
    end
    tick(1);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) din[k] = 2'b00;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_valid", {31'd0, dout[0][0]}, 0);
    check("rst_ack", {31'd0, ack[0]}, 0);
    check("rst_bitcount", {28'd0, dut0.bit_count}, 0);
    rdy[0] = 1'b1;
    base_q = rxq.size();
    send_byte(0, 8'h3C, 1'b0);
    tick(5);
    check("rst_fresh_count", rxq.size() - base_q, 1);
    check("rst_fresh_data", {24'd0, rxq[base_q]}, 32'h3C);

    // Toggle-to-ack latency for 2- and 5-stage synchronizers
    for (int k = 2; k < 4; k++) begin
      toggle_bit(k, 1'b0);
      lat = 0;
      while (ack[k] !== 1'b1 && lat < 20) begin
        tick(1);
        lat++;
      end
      check(k == 2 ? "latency_sync2" : "latency_sync5", lat, k == 2 ? 3 : 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
